useq: RTL and testbench
=======================

Name: useq

Overview:
- Microsequencer (control unit) directly upstream of the datapath: register select, r0–r4/lr/sp/pc, aluB/aluY registers, ALU.
- Fetches a 16-bit instruction from the shared data bus into an internal IR.
- Steps a state machine through micro-cycles, driving every datapath output-enable/load strobe, the ALU function, and the memory handshake.
- Latches ALU carry/zero flags for conditional jumps.

Parameters:
- DATA_BUS_WIDTH, 16, width of dataBus and IR.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dataBus  in  DATA_BUS_WIDTH  shared bus; source of fetched instruction.
- memReady  in  1  memory completes current read/write this cycle.
- aluCout  in  1  ALU carry out.
- aluZout  in  1  ALU zero out.
- ir  out  DATA_BUS_WIDTH  instruction register; fields feed regselOp*.
- regselOE, regselLoad  out  1 each  enable register-file drive / load via regsel.
- regselOESourceSel, regselLoadSourceSel  out  1 each  0 = select from IR field, 1 = sequencer-forced register.
- regselUSeqRegSelOE, regselUSeqRegSelLoad  out  3 each  forced register index (7 = pc).
- pcInc  out  1  increment pc.
- aluBLoad, aluYLoad, aluYOE  out  1 each  ALU operand/result register strobes.
- aluF  out  3  ALU function = ir[14:12].
- memAddrLoad, memRead, memWrite  out  1 each  memory address latch / read / write strobes.
- halted  out  1  sequencer in HALT.

Behaviour:
- Instruction format: op = ir[15:12], dst = ir[11:9], srcA = ir[8:6], srcB = ir[5:3].
- Opcodes: 0 NOP, 1 MOV, 2 LOAD, 3 STORE, 4 JMP, 5 JC, 6 JZ, 7 HALT, 8–15 ALU.
- Outputs are combinational from (state, ir). While reset is low all outputs are 0.
- Async reset: state = FETCH, ir = 0, flags C = Z = 0. Reset mid-instruction abandons it; no partial strobe persists.
- States: FETCH, FETCH_WAIT, T1, T2, T3, HALT.
- FETCH (1 cycle): forced OE of pc (index 7), memAddrLoad. Next state FETCH_WAIT.
- FETCH_WAIT: memRead=1.
  - If memReady: ir <= dataBus, pcInc=1, next T1.
  - Otherwise hold; no cycle limit.
- NOP: T1 does nothing, then FETCH.
- MOV: T1 OE srcA, load dst (both IR-sourced), then FETCH.
- LOAD:
  - T1 OE srcA, memAddrLoad.
  - T2 memRead, load dst; waits in T2 until memReady, and regselLoad is asserted only in the memReady cycle. Then FETCH.
- STORE:
  - T1 OE srcA, memAddrLoad.
  - T2 OE srcB, memWrite until memReady, then FETCH.
- JMP: T1 OE srcA, forced load pc, then FETCH.
- JC / JZ: as JMP when C / Z = 1. Not taken: T1 asserts nothing, then FETCH.
- ALU:
  - T1 OE srcB, aluBLoad.
  - T2 OE srcA, aluYLoad; C <= aluCout and Z <= aluZout at the end of T2.
  - T3 aluYOE, load dst, then FETCH.
- Flags change only in ALU T2.
- HALT: entered from T1 of op 7; halted=1, no strobes; exits only via reset.
- At most one bus driver per cycle: regselOE, aluYOE and the pc forced OE are mutually exclusive.
- Latencies, with zero memory wait: NOP/MOV/JMP/JC/JZ 3 cycles, LOAD/STORE 4, ALU 5. Each memory wait cycle adds 1.
- memReady ignored outside FETCH_WAIT and LOAD/STORE T2.
- dst = 7 on MOV/LOAD/ALU writes pc (a legal jump).

Decomposition:
- Shared include useq_defs.vh: state encodings, opcode constants, field bit positions, PC_INDEX = 7.
- One natural sub-module, useq_decode: purely combinational (state, ir, C, Z, memReady) -> control word.
- useq holds the state register, IR and flags.

Test Plan:
- Reset low mid-ALU T2 -> state FETCH, ir = 0, C = Z = 0, all outputs 0 while low; first cycle after release asserts pcOE-forced + memAddrLoad.
- Fetch 0x1280 (MOV r1 <- r2) with memReady on first FETCH_WAIT cycle -> ir = 0x1280, one pcInc pulse; T1: regselOE=1, regselLoad=1, both source-sels 0; back to FETCH on cycle 4.
- ALU 0x9298 with aluCout=1, aluZout=0 in T2 -> aluF = 1, strobes in order aluBLoad / aluYLoad / aluYOE+load; then JC 0x5100 takes (forced pc load), JZ 0x6100 does not.
- LOAD 0x2280 with memReady low for 3 cycles in T2 -> memRead held 4 cycles, regselLoad only in final cycle.
- STORE 0x3098 with memReady low 2 cycles in FETCH_WAIT -> no pcInc until ready; T2 asserts memWrite with srcB OE until ready.
- HALT 0x7000 -> halted=1 permanently, no strobes, memReady pulses ignored; reset low then high resumes FETCH.

Source files
------------

// File: rtl/useq_pkg.sv
// rtl/useq_pkg.sv - shared definitions for the useq microsequencer
// Purpose: state encodings, opcode constants, instruction field positions,
//          the forced pc register index and the packed control word that
//          useq_decode hands back to useq.
// Ports:   none (package).
package useq_pkg;

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_T1         = 3'd2,
        S_T2         = 3'd3,
        S_T3         = 3'd4,
        S_HALT       = 3'd5
    } stateT;

    // Instruction fields: op = ir[15:12], dst = ir[11:9], srcA = ir[8:6], srcB = ir[5:3].
    // dst/srcA/srcB are decoded by the register-select block straight from ir.
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MOV   = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;
    localparam logic [3:0] OP_JMP   = 4'd4;
    localparam logic [3:0] OP_JC    = 4'd5;
    localparam logic [3:0] OP_JZ    = 4'd6;
    localparam logic [3:0] OP_HALT  = 4'd7;

    localparam logic [2:0] PC_INDEX = 3'd7;

    typedef struct packed {
        logic       regselOE;
        logic       regselLoad;
        logic       regselOESourceSel;
        logic       regselLoadSourceSel;
        logic [2:0] regselUSeqRegSelOE;
        logic [2:0] regselUSeqRegSelLoad;
        logic       pcInc;
        logic       aluBLoad;
        logic       aluYLoad;
        logic       aluYOE;
        logic [2:0] aluF;
        logic       memAddrLoad;
        logic       memRead;
        logic       memWrite;
        logic       halted;
        logic       irLoad;
        logic       flagLoad;
    } ctrlT;

    localparam int CTRL_WIDTH = $bits(ctrlT);

    // Opcodes 8..15 are all ALU operations; the low three bits select the function.
    function automatic logic isAluOp(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/useq_decode.sv
// rtl/useq_decode.sv - combinational next-state and control-word decode
// Purpose: from (state, opcode, flags, memReady) produce the next state and
//          every datapath/memory strobe for the current micro-cycle.
// Ports:   state     in  current sequencer state
//          op        in  ir[15:12]
//          flagC/Z   in  latched ALU carry / zero
//          memReady  in  memory handshake
//          nextState out state to load on the next clock
//          ctrlWord  out packed ctrlT control word
module useq_decode
    import useq_pkg::*;
(
    input  logic [2:0]            state,
    input  logic [3:0]            op,
    input  logic                  flagC,
    input  logic                  flagZ,
    input  logic                  memReady,
    output logic [2:0]            nextState,
    output logic [CTRL_WIDTH-1:0] ctrlWord
);

    stateT cur;
    stateT nxt;
    ctrlT  c;
    logic  jumpTaken;

    assign cur       = stateT'(state);
    assign nextState = nxt;
    assign ctrlWord  = c;

    assign jumpTaken = (op == OP_JMP) || ((op == OP_JC) && flagC) || ((op == OP_JZ) && flagZ);

    always_comb begin
        nxt = cur;
        unique case (cur)
            S_FETCH:      nxt = S_FETCH_WAIT;
            S_FETCH_WAIT: nxt = memReady ? S_T1 : S_FETCH_WAIT;
            S_T1: begin
                if (op == OP_HALT)
                    nxt = S_HALT;
                else if (isAluOp(op) || (op == OP_LOAD) || (op == OP_STORE))
                    nxt = S_T2;
                else
                    nxt = S_FETCH;
            end
            S_T2: begin
                if (isAluOp(op))
                    nxt = S_T3;
                else
                    nxt = memReady ? S_FETCH : S_T2;
            end
            S_T3:   nxt = S_FETCH;
            S_HALT: nxt = S_HALT;
            default: nxt = S_FETCH;
        endcase
    end

    always_comb begin
        c      = '0;
        c.aluF = op[2:0];
        unique case (cur)
            S_FETCH: begin
                c.regselOE           = 1'b1;
                c.regselOESourceSel  = 1'b1;
                c.regselUSeqRegSelOE = PC_INDEX;
                c.memAddrLoad        = 1'b1;
            end
            S_FETCH_WAIT: begin
                c.memRead = 1'b1;
                c.pcInc   = memReady;
                c.irLoad  = memReady;
            end
            S_T1: begin
                if (isAluOp(op)) begin
                    c.regselOE = 1'b1;
                    c.aluBLoad = 1'b1;
                end else if (op == OP_MOV) begin
                    c.regselOE   = 1'b1;
                    c.regselLoad = 1'b1;
                end else if ((op == OP_LOAD) || (op == OP_STORE)) begin
                    c.regselOE    = 1'b1;
                    c.memAddrLoad = 1'b1;
                end else if (jumpTaken) begin
                    c.regselOE             = 1'b1;
                    c.regselLoad           = 1'b1;
                    c.regselLoadSourceSel  = 1'b1;
                    c.regselUSeqRegSelLoad = PC_INDEX;
                end
            end
            S_T2: begin
                if (isAluOp(op)) begin
                    c.regselOE = 1'b1;
                    c.aluYLoad = 1'b1;
                    c.flagLoad = 1'b1;
                end else if (op == OP_LOAD) begin
                    c.memRead    = 1'b1;
                    // Only write the register once the read data is valid on the bus.
                    c.regselLoad = memReady;
                end else if (op == OP_STORE) begin
                    c.regselOE = 1'b1;
                    c.memWrite = 1'b1;
                end
            end
            S_T3: begin
                c.aluYOE     = 1'b1;
                c.regselLoad = 1'b1;
            end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/useq.sv
// rtl/useq.sv - microsequencer top: state register, IR and ALU flags
// Purpose: fetch 16-bit instructions from dataBus and step them through
//          micro-cycles, driving register-select, ALU and memory strobes.
// Ports:   clock, reset (async active-low), dataBus, memReady, aluCout, aluZout in;
//          ir, regsel* strobes/selects, pcInc, aluBLoad/aluYLoad/aluYOE, aluF,
//          memAddrLoad/memRead/memWrite, halted out.
module useq
    import useq_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_BUS_WIDTH-1:0] dataBus,
    input  logic                      memReady,
    input  logic                      aluCout,
    input  logic                      aluZout,
    output logic [DATA_BUS_WIDTH-1:0] ir,
    output logic                      regselOE,
    output logic                      regselLoad,
    output logic                      regselOESourceSel,
    output logic                      regselLoadSourceSel,
    output logic [2:0]                regselUSeqRegSelOE,
    output logic [2:0]                regselUSeqRegSelLoad,
    output logic                      pcInc,
    output logic                      aluBLoad,
    output logic                      aluYLoad,
    output logic                      aluYOE,
    output logic [2:0]                aluF,
    output logic                      memAddrLoad,
    output logic                      memRead,
    output logic                      memWrite,
    output logic                      halted
);

    logic [2:0]                state;
    logic [2:0]                nextState;
    logic [DATA_BUS_WIDTH-1:0] irQ;
    logic                      flagC;
    logic                      flagZ;
    logic [CTRL_WIDTH-1:0]     ctrlWord;
    ctrlT                      ctrl;

    useq_decode uDecode (
        .state     (state),
        .op        (irQ[OP_MSB:OP_LSB]),
        .flagC     (flagC),
        .flagZ     (flagZ),
        .memReady  (memReady),
        .nextState (nextState),
        .ctrlWord  (ctrlWord)
    );

    // While reset is held the state already sits in FETCH, whose decode would
    // drive pc onto the bus; gate everything so the datapath sees no strobes.
    assign ctrl = reset ? ctrlT'(ctrlWord) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            irQ   <= '0;
            flagC <= 1'b0;
            flagZ <= 1'b0;
        end else begin
            state <= nextState;
            if (ctrl.irLoad)
                irQ <= dataBus;
            if (ctrl.flagLoad) begin
                flagC <= aluCout;
                flagZ <= aluZout;
            end
        end
    end

    assign ir                   = irQ;
    assign regselOE             = ctrl.regselOE;
    assign regselLoad           = ctrl.regselLoad;
    assign regselOESourceSel    = ctrl.regselOESourceSel;
    assign regselLoadSourceSel  = ctrl.regselLoadSourceSel;
    assign regselUSeqRegSelOE   = ctrl.regselUSeqRegSelOE;
    assign regselUSeqRegSelLoad = ctrl.regselUSeqRegSelLoad;
    assign pcInc                = ctrl.pcInc;
    assign aluBLoad             = ctrl.aluBLoad;
    assign aluYLoad             = ctrl.aluYLoad;
    assign aluYOE               = ctrl.aluYOE;
    assign aluF                 = ctrl.aluF;
    assign memAddrLoad          = ctrl.memAddrLoad;
    assign memRead              = ctrl.memRead;
    assign memWrite             = ctrl.memWrite;
    assign halted               = ctrl.halted;

endmodule

// File: tb/tb_useq.sv
// tb/tb_useq.sv - self-checking bench for the useq microsequencer
module tb_useq;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] dataBus;
    logic        memReady;
    logic        aluCout;
    logic        aluZout;
    logic [15:0] ir;
    logic        regselOE, regselLoad, regselOESourceSel, regselLoadSourceSel;
    logic [2:0]  regselUSeqRegSelOE, regselUSeqRegSelLoad;
    logic        pcInc, aluBLoad, aluYLoad, aluYOE;
    logic [2:0]  aluF;
    logic        memAddrLoad, memRead, memWrite, halted;

    useq #(.DATA_BUS_WIDTH(16)) dut (
        .clock                (clock),
        .reset                (reset),
        .dataBus              (dataBus),
        .memReady             (memReady),
        .aluCout              (aluCout),
        .aluZout              (aluZout),
        .ir                   (ir),
        .regselOE             (regselOE),
        .regselLoad           (regselLoad),
        .regselOESourceSel    (regselOESourceSel),
        .regselLoadSourceSel  (regselLoadSourceSel),
        .regselUSeqRegSelOE   (regselUSeqRegSelOE),
        .regselUSeqRegSelLoad (regselUSeqRegSelLoad),
        .pcInc                (pcInc),
        .aluBLoad             (aluBLoad),
        .aluYLoad             (aluYLoad),
        .aluYOE               (aluYOE),
        .aluF                 (aluF),
        .memAddrLoad          (memAddrLoad),
        .memRead              (memRead),
        .memWrite             (memWrite),
        .halted               (halted)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       oe;
        logic       ld;
        logic       oeSel;
        logic       ldSel;
        logic [2:0] uOE;
        logic [2:0] uLd;
        logic       pcInc;
        logic       bLoad;
        logic       yLoad;
        logic       yOE;
        logic [2:0] aluF;
        logic       mal;
        logic       mRd;
        logic       mWr;
        logic       halted;
    } outsT;

    outsT dutOuts;
    assign dutOuts = {regselOE, regselLoad, regselOESourceSel, regselLoadSourceSel,
                      regselUSeqRegSelOE, regselUSeqRegSelLoad, pcInc, aluBLoad,
                      aluYLoad, aluYOE, aluF, memAddrLoad, memRead, memWrite, halted};

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] curIr    = 16'h0;
    bit          mC       = 1'b0;
    bit          mZ       = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic outsT base();
        outsT o;
        o      = '0;
        o.aluF = curIr[14:12];
        return o;
    endfunction

    function automatic outsT t1Exp(input bit oe, input bit ld, input bit ldSel,
                                   input bit mal, input bit bLoad, input logic [2:0] f);
        outsT o;
        o       = '0;
        o.oe    = oe;
        o.ld    = ld;
        o.ldSel = ldSel;
        o.uLd   = ldSel ? 3'd7 : 3'd0;
        o.mal   = mal;
        o.bLoad = bLoad;
        o.aluF  = f;
        return o;
    endfunction

    task automatic junk();
        dataBus  = 16'($urandom);
        memReady = 1'($urandom);
        aluCout  = 1'($urandom);
        aluZout  = 1'($urandom);
    endtask

    task automatic step(input string name, input outsT e);
        #1;
        check({name, ".outs"}, 32'(dutOuts), 32'(e));
        check({name, ".ir"}, 32'(ir), 32'(curIr));
        @(negedge clock);
    endtask

    // Reference: one instruction from its FETCH cycle up to (not including) the next FETCH.
    task automatic execInstr(input logic [15:0] instr, input int fw, input int mw,
                             input bit co, input bit zo, output int cyc, output outsT t1Got);
        outsT       e;
        logic [3:0] op;
        bit         take;
        op  = instr[15:12];
        cyc = 0;
        junk();
        e = base(); e.oe = 1; e.oeSel = 1; e.uOE = 3'd7; e.mal = 1;
        step("fetch", e); cyc++;
        for (int i = 0; i < fw; i++) begin
            junk(); memReady = 1'b0;
            e = base(); e.mRd = 1;
            step("fetchWait", e); cyc++;
        end
        junk(); memReady = 1'b1; dataBus = instr;
        e = base(); e.mRd = 1; e.pcInc = 1;
        step("fetchReady", e); cyc++;
        curIr = instr;

        junk();
        e    = base();
        take = (op == 4'd4) || ((op == 4'd5) && mC) || ((op == 4'd6) && mZ);
        if (op >= 4'd8) begin
            e.oe = 1; e.bLoad = 1;
        end else if (op == 4'd1) begin
            e.oe = 1; e.ld = 1;
        end else if ((op == 4'd2) || (op == 4'd3)) begin
            e.oe = 1; e.mal = 1;
        end else if (take) begin
            e.oe = 1; e.ld = 1; e.ldSel = 1; e.uLd = 3'd7;
        end
        #1;
        t1Got = dutOuts;
        step("t1", e); cyc++;

        if ((op == 4'd2) || (op == 4'd3)) begin
            for (int i = 0; i <= mw; i++) begin
                junk(); memReady = (i == mw);
                e = base();
                if (op == 4'd2) begin
                    e.mRd = 1; e.ld = (i == mw);
                end else begin
                    e.oe = 1; e.mWr = 1;
                end
                step("memT2", e); cyc++;
            end
        end else if (op >= 4'd8) begin
            junk(); aluCout = co; aluZout = zo;
            e = base(); e.oe = 1; e.yLoad = 1;
            step("aluT2", e); cyc++;
            mC = co; mZ = zo;
            junk();
            e = base(); e.yOE = 1; e.ld = 1;
            step("aluT3", e); cyc++;
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        int          fw;
        int          mw;
        bit          co;
        bit          zo;
        outsT        expT1;
        int          expLat;
    } vecT;

    vecT  tbl[12];
    int   cyc;
    outsT t1Got;
    outsT e;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{16'h1280, 0, 0, 1'b0, 1'b0, t1Exp(1, 1, 0, 0, 0, 3'd1), 3};
        tbl[1]  = '{16'h9298, 0, 0, 1'b1, 1'b0, t1Exp(1, 0, 0, 0, 1, 3'd1), 5};
        tbl[2]  = '{16'h5100, 0, 0, 1'b0, 1'b0, t1Exp(1, 1, 1, 0, 0, 3'd5), 3};
        tbl[3]  = '{16'h6100, 0, 0, 1'b0, 1'b0, t1Exp(0, 0, 0, 0, 0, 3'd6), 3};
        tbl[4]  = '{16'h2280, 0, 3, 1'b0, 1'b0, t1Exp(1, 0, 0, 1, 0, 3'd2), 7};
        tbl[5]  = '{16'h3098, 2, 2, 1'b0, 1'b0, t1Exp(1, 0, 0, 1, 0, 3'd3), 8};
        tbl[6]  = '{16'h0000, 1, 0, 1'b0, 1'b0, t1Exp(0, 0, 0, 0, 0, 3'd0), 4};
        tbl[7]  = '{16'hFE10, 1, 0, 1'b0, 1'b1, t1Exp(1, 0, 0, 0, 1, 3'd7), 6};
        tbl[8]  = '{16'h6100, 0, 0, 1'b0, 1'b0, t1Exp(1, 1, 1, 0, 0, 3'd6), 3};
        tbl[9]  = '{16'h5100, 0, 0, 1'b0, 1'b0, t1Exp(0, 0, 0, 0, 0, 3'd5), 3};
        tbl[10] = '{16'h4040, 0, 0, 1'b0, 1'b0, t1Exp(1, 1, 1, 0, 0, 3'd4), 3};
        tbl[11] = '{16'h2E00, 0, 0, 1'b0, 1'b0, t1Exp(1, 0, 0, 1, 0, 3'd2), 4};

        // Power-on reset: nothing may be driven while reset is low.
        reset = 1'b0;
        junk();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            junk();
            #1;
            check("resetOuts", 32'(dutOuts), 32'h0);
            check("resetIr", 32'(ir), 32'h0);
        end
        @(negedge clock);
        reset = 1'b1;

        // Directed table.
        foreach (tbl[i]) begin
            execInstr(tbl[i].instr, tbl[i].fw, tbl[i].mw, tbl[i].co, tbl[i].zo, cyc, t1Got);
            check($sformatf("tbl%0d.t1", i), 32'(t1Got), 32'(tbl[i].expT1));
            #1;
            check($sformatf("tbl%0d.latency", i),
                  (memAddrLoad && regselOESourceSel && !pcInc) ? cyc : -1, tbl[i].expLat);
        end

        // Reset mid-ALU T2 (model flags are C=0 Z=1 here) abandons the instruction.
        junk();
        e = base(); e.oe = 1; e.oeSel = 1; e.uOE = 3'd7; e.mal = 1;
        step("rstFetch", e);
        junk(); memReady = 1'b1; dataBus = 16'h9298;
        e = base(); e.mRd = 1; e.pcInc = 1;
        step("rstFetchReady", e);
        curIr = 16'h9298;
        junk();
        e = base(); e.oe = 1; e.bLoad = 1;
        step("rstT1", e);
        junk(); aluCout = 1'b1; aluZout = 1'b1;
        e = base(); e.oe = 1; e.yLoad = 1;
        #1;
        check("rstT2.outs", 32'(dutOuts), 32'(e));
        #1;
        reset = 1'b0;
        curIr = 16'h0;
        mC = 1'b0;
        mZ = 1'b0;
        #1;
        check("rstMid.outs", 32'(dutOuts), 32'h0);
        check("rstMid.ir", 32'(ir), 32'h0);
        @(negedge clock);
        junk();
        #1;
        check("rstHold.outs", 32'(dutOuts), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        execInstr(16'h5100, 0, 0, 1'b0, 1'b0, cyc, t1Got);
        check("postRstJc.t1", 32'(t1Got), 32'(t1Exp(0, 0, 0, 0, 0, 3'd5)));
        execInstr(16'h6100, 0, 0, 1'b0, 1'b0, cyc, t1Got);
        check("postRstJz.t1", 32'(t1Got), 32'(t1Exp(0, 0, 0, 0, 0, 3'd6)));

        // HALT is sticky until reset, whatever memReady does.
        execInstr(16'h7000, 1, 0, 1'b0, 1'b0, cyc, t1Got);
        check("halt.t1", 32'(t1Got), 32'(t1Exp(0, 0, 0, 0, 0, 3'd7)));
        for (int i = 0; i < 6; i++) begin
            junk(); memReady = i[0];
            e = base(); e.halted = 1;
            step("halted", e);
        end
        reset = 1'b0;
        curIr = 16'h0;
        mC = 1'b0;
        mZ = 1'b0;
        #1;
        check("haltRst.outs", 32'(dutOuts), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        execInstr(16'h1280, 0, 0, 1'b0, 1'b0, cyc, t1Got);

        // Randomized instruction stream against the reference.
        for (int n = 0; n < 300; n++) begin
            int          opv;
            logic [15:0] instr;
            opv = int'($urandom_range(0, 14));
            if (opv >= 7) opv++;
            instr = {4'(opv), 12'($urandom)};
            execInstr(instr, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), cyc, t1Got);
        end
        #1;
        check("finalFetch", 32'({memAddrLoad, regselOESourceSel, regselUSeqRegSelOE}), 32'h1F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
